// File: rtl/alarm_pkg.sv
// ============================================================================
// alarm_pkg : shared types and constants for the multi-channel alarm block
// Revision  : 1.0
// ============================================================================
`default_nettype none

package alarm_pkg;

  localparam int TIME_W = 24;

  // Bit offsets of each BCD digit inside the packed time word
  localparam int SEC_L_LSB  = 0;
  localparam int SEC_H_LSB  = 4;
  localparam int MIN_L_LSB  = 8;
  localparam int MIN_H_LSB  = 12;
  localparam int HOUR_L_LSB = 16;
  localparam int HOUR_H_LSB = 20;

  typedef struct packed {
    logic [3:0] hour_h;
    logic [3:0] hour_l;
    logic [3:0] min_h;
    logic [3:0] min_l;
    logic [3:0] sec_h;
    logic [3:0] sec_l;
  } bcd_time_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alarm_channel.sv
// ============================================================================
// alarm_channel : one set-point comparator with ring/snooze/dismiss FSM.
// Optional feature macro: ALARM_SNOOZE_EN (adds snooze input and SNOOZE state)
// Revision      : 1.0
// ============================================================================
`default_nettype none

module alarm_channel
  import alarm_pkg::*;
#(
  parameter int RING_SECS   = 10
`ifdef ALARM_SNOOZE_EN
  ,
  parameter int SNOOZE_SECS = 300
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TIME_W-1:0] cur_time,
  input  logic [TIME_W-1:0] alarm_time,
  input  logic              en,
  input  logic              stop,
`ifdef ALARM_SNOOZE_EN
  input  logic              snooze,
`endif
  output logic              ring,
  output logic              ring_next
);

`ifdef ALARM_SNOOZE_EN
  localparam int CNT_MAX = max_int(RING_SECS, SNOOZE_SECS);
`else
  localparam int CNT_MAX = RING_SECS;
`endif
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] RING_LOAD = CNT_W'(RING_SECS - 1);
`ifdef ALARM_SNOOZE_EN
  localparam logic [CNT_W-1:0] SNOOZE_LOAD = CNT_W'(SNOOZE_SECS - 1);
`endif

  bcd_time_t        now_t;
  bcd_time_t        set_t;
  logic             match;
  state_e           state;
  state_e           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;

  assign now_t = cur_time;
  assign set_t = alarm_time;
  assign match = en && (now_t == set_t);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      ST_IDLE: begin
        if (!stop && match) begin
          state_n = ST_RING;
          cnt_n   = RING_LOAD;
        end
      end
      ST_RING: begin
        if (stop || !en) begin
          state_n = ST_IDLE;
`ifdef ALARM_SNOOZE_EN
        end else if (snooze) begin
          state_n = ST_SNOOZE;
          cnt_n   = SNOOZE_LOAD;
`endif
        end else if (cnt == '0) begin
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
`ifdef ALARM_SNOOZE_EN
      ST_SNOOZE: begin
        if (stop || !en) begin
          state_n = ST_IDLE;
        end else if (match || cnt == '0) begin
          state_n = ST_RING;
          cnt_n   = RING_LOAD;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
`endif
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  assign ring      = (state == ST_RING);
  assign ring_next = (state_n == ST_RING);

endmodule

`default_nettype wire

// File: rtl/alarm_multi.sv
// ============================================================================
// alarm_multi : N-channel alarm controller with shared blinking active-low LED.
// Optional feature macro: ALARM_SNOOZE_EN (global snooze input)
// Revision    : 1.0
// ============================================================================
`default_nettype none

module alarm_multi
  import alarm_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int RING_SECS   = 10,
  parameter int SNOOZE_SECS = 300,
  parameter int BLINK       = 1,
  localparam int CW         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                   div_clk,
  input  logic                   rst,
  input  logic [TIME_W-1:0]      cur_time,
  input  logic [TIME_W*N_CH-1:0] alarm_time,
  input  logic [N_CH-1:0]        alarm_en,
  input  logic                   stop,
`ifdef ALARM_SNOOZE_EN
  input  logic                   snooze,
`endif
  output logic                   alarm_led,
  output logic [N_CH-1:0]        ringing,
  output logic                   alarm_any,
  output logic [CW-1:0]          active_ch
);

  localparam logic BLINK_ON = (BLINK != 0);

  if (N_CH < 1 || N_CH > 8 || RING_SECS < 1 || SNOOZE_SECS < 1) begin : g_param_check
    $error("alarm_multi: parameter out of range");
  end

  logic [N_CH-1:0] ring_next;
  logic            any_n;
  logic [CW-1:0]   active_n;
  logic            phase;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    alarm_channel #(
      .RING_SECS   (RING_SECS)
`ifdef ALARM_SNOOZE_EN
      ,
      .SNOOZE_SECS (SNOOZE_SECS)
`endif
    ) u_channel (
      .clk        (div_clk),
      .rst        (rst),
      .cur_time   (cur_time),
      .alarm_time (alarm_time[TIME_W*i +: TIME_W]),
      .en         (alarm_en[i]),
      .stop       (stop),
`ifdef ALARM_SNOOZE_EN
      .snooze     (snooze),
`endif
      .ring       (ringing[i]),
      .ring_next  (ring_next[i])
    );
  end

  assign any_n = |ring_next;

  // Scan from the top so the lowest ringing index is the last one written
  always_comb begin
    active_n = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (ring_next[i]) active_n = CW'(i);
    end
  end

  // Phase is 0 on the first ringing tick, so the LED starts lit
  always_ff @(posedge div_clk or posedge rst) begin
    if (rst) begin
      phase     <= 1'b0;
      alarm_led <= 1'b1;
      alarm_any <= 1'b0;
      active_ch <= '0;
    end else begin
      phase     <= any_n ? ~phase : 1'b0;
      alarm_led <= ~(any_n && (!BLINK_ON || !phase));
      alarm_any <= any_n;
      active_ch <= active_n;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alarm_multi.sv
// ============================================================================
// tb_alarm_multi : scoreboard bench for alarm_multi (4 channels, ring 10 ticks)
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_alarm_multi;

  localparam logic [23:0] T0 = 24'h073000;
  localparam logic [23:0] T1 = 24'h081500;
  localparam logic [23:0] T2 = 24'h093000;
  localparam logic [23:0] IT = 24'h120000;

  logic        div_clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] cur_time = IT;
  logic [95:0] alarm_time = {T0, T2, T1, T0};
  logic [3:0]  alarm_en = 4'b0000;
  logic        stop = 1'b0;
  logic        snooze = 1'b0;
  logic        alarm_led;
  logic [3:0]  ringing;
  logic        alarm_any;
  logic [1:0]  active_ch;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] ring;
    logic       any;
    logic [1:0] act;
    logic       led;
    string      name;
  } exp_t;

  exp_t q[$];

  alarm_multi #(
    .N_CH        (4),
    .RING_SECS   (10),
    .SNOOZE_SECS (5),
    .BLINK       (1)
  ) dut (
    .div_clk    (div_clk),
    .rst        (rst),
    .cur_time   (cur_time),
    .alarm_time (alarm_time),
    .alarm_en   (alarm_en),
    .stop       (stop),
`ifdef ALARM_SNOOZE_EN
    .snooze     (snooze),
`endif
    .alarm_led  (alarm_led),
    .ringing    (ringing),
    .alarm_any  (alarm_any),
    .active_ch  (active_ch)
  );

  always #5 div_clk = ~div_clk;

  task automatic check(input exp_t e);
    checks++;
    if (ringing !== e.ring || alarm_any !== e.any || active_ch !== e.act || alarm_led !== e.led) begin
      errors++;
      $display("FAIL %s: got ringing=%b any=%b active_ch=%0d led=%b, want ringing=%b any=%b active_ch=%0d led=%b",
               e.name, ringing, alarm_any, active_ch, alarm_led, e.ring, e.any, e.act, e.led);
    end
  endtask

  task automatic expect_out(input logic [3:0] er, input logic [1:0] ea, input logic el, input string nm);
    exp_t e;
    e.ring = er; e.any = |er; e.act = ea; e.led = el; e.name = nm;
    q.push_back(e);
  endtask

  task automatic step(input logic [23:0] t, input logic [3:0] en, input logic stp, input logic snz,
                      input logic [3:0] er, input logic [1:0] ea, input logic el, input string nm);
    @(negedge div_clk);
    cur_time = t; alarm_en = en; stop = stp; snooze = snz;
    expect_out(er, ea, el, nm);
  endtask

  // Monitor: every edge presents a new output word
  always @(posedge div_clk) begin
    #1;
    if (q.size() > 0) check(q.pop_front());
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    step(IT, 4'b0000, 0, 0, 4'b0000, 0, 1, "reset");
    step(IT, 4'b0000, 0, 0, 4'b0000, 0, 1, "reset");
    @(negedge div_clk); rst = 1'b0;

    // Single channel rings exactly 10 ticks, LED lit first then alternating
    step(IT, 4'b0001, 0, 0, 4'b0000, 0, 1, "a_idle");
    for (int k = 1; k <= 10; k++)
      step((k == 1) ? T0 : IT, 4'b0001, 0, 0, 4'b0001, 0, (k % 2 == 0), "a_ring");
    step(IT, 4'b0001, 0, 0, 4'b0000, 0, 1, "a_end");

    // Stop on tick 3 dismisses, no re-ring; stop with match in IDLE stays idle
    step(T1, 4'b0010, 0, 0, 4'b0010, 1, 0, "b_t1");
    step(IT, 4'b0010, 0, 0, 4'b0010, 1, 1, "b_t2");
    step(IT, 4'b0010, 1, 0, 4'b0000, 0, 1, "b_stop");
    for (int k = 0; k < 3; k++) step(IT, 4'b0010, 0, 0, 4'b0000, 0, 1, "b_no_rering");
    step(T1, 4'b0010, 1, 0, 4'b0000, 0, 1, "b_stop_match");
    step(IT, 4'b0010, 0, 0, 4'b0000, 0, 1, "b_after");

`ifdef ALARM_SNOOZE_EN
    // Snooze at tick 2: silent for 5 ticks, then a full 10-tick ring
    step(T2, 4'b0100, 0, 0, 4'b0100, 2, 0, "c_t1");
    step(IT, 4'b0100, 0, 1, 4'b0000, 0, 1, "c_snooze");
    for (int k = 0; k < 4; k++) step(IT, 4'b0100, 0, 0, 4'b0000, 0, 1, "c_snoozing");
    for (int k = 1; k <= 10; k++)
      step(IT, 4'b0100, 0, 0, 4'b0100, 2, (k % 2 == 0), "c_rering");
    step(IT, 4'b0100, 0, 0, 4'b0000, 0, 1, "c_end");
    // stop beats snooze: no return after the snooze delay
    step(T2, 4'b0100, 0, 0, 4'b0100, 2, 0, "c2_t1");
    step(IT, 4'b0100, 1, 1, 4'b0000, 0, 1, "c2_stop_snooze");
    for (int k = 0; k < 6; k++) step(IT, 4'b0100, 0, 0, 4'b0000, 0, 1, "c2_quiet");
`endif

    // Two channels on the same set-point; drop ch0 via enable
    step(T0, 4'b1001, 0, 0, 4'b1001, 0, 0, "d_both");
    step(IT, 4'b1000, 0, 0, 4'b1000, 3, 1, "d_ch3_only");
    step(IT, 4'b1000, 0, 0, 4'b1000, 3, 0, "d_ch3_t3");
    step(IT, 4'b1000, 1, 0, 4'b0000, 0, 1, "d_stop");

    // Disabled channel and one-digit mismatch never ring
    step(T1, 4'b0000, 0, 0, 4'b0000, 0, 1, "e_disabled");
    step(24'h073001, 4'b0001, 0, 0, 4'b0000, 0, 1, "e_sec_mismatch");
    step(IT, 4'b0001, 0, 0, 4'b0000, 0, 1, "e_idle");

    // Asynchronous reset mid-ring, then re-ring on the first edge after release
    step(T0, 4'b0001, 0, 0, 4'b0001, 0, 0, "f_t1");
    step(IT, 4'b0001, 0, 0, 4'b0001, 0, 1, "f_t2");
    step(IT, 4'b0001, 0, 0, 4'b0001, 0, 0, "f_t3");
    step(IT, 4'b0001, 0, 0, 4'b0001, 0, 1, "f_t4");
    @(negedge div_clk);
    rst = 1'b1; cur_time = T0;
    #1;
    e.ring = 4'b0000; e.any = 1'b0; e.act = 2'd0; e.led = 1'b1; e.name = "f_async_rst";
    check(e);
    expect_out(4'b0000, 0, 1, "f_rst_hold");
    @(negedge div_clk);
    rst = 1'b0;
    expect_out(4'b0001, 0, 0, "f_rering");
    step(IT, 4'b0001, 0, 0, 4'b0001, 0, 1, "f_rering_t2");
    step(IT, 4'b0001, 1, 0, 4'b0000, 0, 1, "f_stop");

    repeat (3) @(posedge div_clk);
    #2;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
